mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and ack (range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port f_req  input  1  fetch request, held high until f_ack.
REQ-006 SHALL have port f_addr  input  8  fetch word address (program counter).
REQ-007 SHALL have port f_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port f_instr  output  32  fetched instruction, valid while f_ack high.
REQ-009 SHALL have port d_req  input  1  data request, held high until d_ack.
REQ-010 SHALL have port d_we  input  1  1 = write (STR), 0 = read (LDR).
REQ-011 SHALL have port d_addr  input  16  data word address.
REQ-012 SHALL have port d_wdata  input  32  store data.
REQ-013 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port d_rdata  output  32  load data, valid while d_ack high.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_STATES = 0.
REQ-017 SHALL, in IDLE, sample f_req/d_req at each edge; a high request is accepted and its address, d_we and d_wdata are latched on that edge.
REQ-018 SHALL, when both requests are high in IDLE, grant the port not granted last; last-grant resets to fetch, so data wins the first tie.
REQ-019 SHALL, when one request is high, grant that port regardless of last-grant.
REQ-020 SHALL count WAIT_STATES cycles in WAIT with a 4-bit down-counter loaded on accept.
REQ-021 SHALL assert exactly one of f_ack/d_ack for exactly one cycle in RESP; ack rises WAIT_STATES+1 cycles after the accepting edge.
REQ-022 SHALL drive f_instr/d_rdata from the latched address during the ack cycle, and hold the last value otherwise.
REQ-023 SHALL commit a write to the array on the edge that leaves RESP; a read in the same transaction returns pre-write data.
REQ-024 SHALL use only the latched values; input changes after accept have no effect on the current transaction.
REQ-025 SHALL treat a request still high in the IDLE cycle following an ack as a new transaction; requesters drop req on the edge that samples ack.
REQ-026 SHALL, for addresses >= DEPTH: return 0 on reads, ignore writes, and still ack.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, f_ack = 0, d_ack = 0, f_instr = 0, d_rdata = 0, busy = 0, counter 0, and last-grant = fetch.
REQ-028 SHALL abandon any in-flight transaction on reset without acking it; an uncommitted write is discarded.
REQ-029 SHALL not reset array contents; unwritten locations are undefined.

Configuration
REQ-030 SHALL, when MEM_RESP_ERR_EN is defined, add output d_err (1 bit, reset 0), high with d_ack when the data address is >= DEPTH (fetch addresses are always in range at DEPTH >= 256).
REQ-031 SHALL, when MEM_RESP_ERR_EN is undefined, omit d_err; out-of-range behaviour per REQ-026 is unchanged.

Structure
REQ-032 SHALL place the FSM state encoding, the 32-bit data width constant and the address widths (8 fetch, 16 data) in the shared processor package.
REQ-033 SHALL split the storage array into sub-module mem_array (one read port, one write port, synchronous write); arbitration, FSM and counter stay in mem_responder.

Verification
REQ-034 Bench SHALL write 0xDEADBEEF to d_addr 0x0010, then read d_addr 0x0010 -> d_rdata = 0xDEADBEEF with d_ack 2 cycles after accept (WAIT_STATES = 1).
REQ-035 Bench SHALL preload word 0x05 = 0xE1A00000 and raise f_req with f_addr 0x05 -> one-cycle f_ack with f_instr = 0xE1A00000.
REQ-036 Bench SHALL raise f_req and d_req on the same edge, held through three transactions -> grant order data, fetch, data.
REQ-037 Bench SHALL write 0x12345678 to d_addr 0x0100 (DEPTH = 256) -> d_ack, array unchanged, read returns 0, d_err = 1 if MEM_RESP_ERR_EN.
REQ-038 Bench SHALL pulse rst_n low during WAIT of a write of 0xCAFEF00D to 0x0020 -> no ack, outputs zero, state IDLE, location 0x0020 unchanged.
REQ-039 Bench SHALL set WAIT_STATES = 0 and issue back-to-back reads -> ack one cycle after each accept, with one IDLE cycle between transactions.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: data/address widths, FSM state
// encoding, port identifiers and an address range helper.
package mem_responder_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned F_ADDR_W = 8;
  localparam int unsigned D_ADDR_W = 16;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Port identifiers, used for the current grant and the last grant
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // True when a word address falls inside an array of the given depth
  function automatic logic addr_in_range(input logic [D_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return (32'(addr) < depth);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word-wide storage for the memory responder: one registered read port and
// one synchronous write port. Contents are never reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Synchronous write and registered read; the read register only moves when
  // a new transaction is accepted so it holds its word through WAIT.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving a fetch port and a data port from one array.
// One transaction at a time: IDLE -> WAIT (WAIT_STATES cycles) -> RESP -> IDLE.
// Optional feature macro: MEM_RESP_ERR_EN adds the d_err output flagging
// out-of-range data accesses.
// Note: data addresses are truncated to $clog2(DEPTH) bits for the array, so
// DEPTH must not exceed 65536.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f_req,
  input  logic [F_ADDR_W-1:0] f_addr,
  output logic                f_ack,
  output logic [DATA_W-1:0]   f_instr,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [D_ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
`ifdef MEM_RESP_ERR_EN
  output logic                d_err,
`endif
  output logic                busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              last_q, last_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              in_range_q, in_range_d;
  logic [DATA_W-1:0] f_hold_q, f_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;

  logic                req_any;
  logic                grant_data;
  logic [D_ADDR_W-1:0] acc_addr;
  logic                mem_re;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   rd_masked;

  // On a tie the port not granted last wins; a lone request always wins.
  assign req_any    = f_req | d_req;
  assign grant_data = d_req & (~f_req | (last_q == PORT_FETCH));
  assign acc_addr   = grant_data ? d_addr : {{(D_ADDR_W-F_ADDR_W){1'b0}}, f_addr};

  // The array is read on the accepting edge straight from the request address
  // so the word is ready even when RESP follows accept directly. The write
  // lands on the edge leaving RESP, after the pre-write word was returned.
  assign mem_re    = (state_q == ST_IDLE) & req_any;
  assign mem_we    = (state_q == ST_RESP) & we_q & in_range_q;
  assign rd_masked = in_range_q ? mem_rdata : '0;

  assign f_ack   = (state_q == ST_RESP) & (port_q == PORT_FETCH);
  assign d_ack   = (state_q == ST_RESP) & (port_q == PORT_DATA);
  assign f_instr = f_ack ? rd_masked : f_hold_q;
  assign d_rdata = d_ack ? rd_masked : d_hold_q;
  assign busy    = (state_q != ST_IDLE);
`ifdef MEM_RESP_ERR_EN
  assign d_err   = d_ack & ~in_range_q;
`endif

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .re    (mem_re),
    .raddr (acc_addr[AW-1:0]),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q)
  );

  // Next-state logic: arbitration and latching on accept, wait countdown, ack.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    last_d     = last_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    in_range_d = in_range_q;
    f_hold_d   = f_ack ? rd_masked : f_hold_q;
    d_hold_d   = d_ack ? rd_masked : d_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          port_d     = grant_data ? PORT_DATA : PORT_FETCH;
          last_d     = grant_data ? PORT_DATA : PORT_FETCH;
          addr_d     = acc_addr[AW-1:0];
          we_d       = grant_data & d_we;
          wdata_d    = d_wdata;
          in_range_d = addr_in_range(acc_addr, DEPTH);
          cnt_d      = 4'(WAIT_STATES);
          state_d    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      port_q     <= PORT_FETCH;
      last_q     <= PORT_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      f_hold_q   <= '0;
      d_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      in_range_q <= in_range_d;
      f_hold_q   <= f_hold_d;
      d_hold_q   <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_STATES = 1 and one
// with WAIT_STATES = 0. Checks d_err when MEM_RESP_ERR_EN is defined.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        fa_req, fa_ack, da_req, da_we, da_ack, busy_a, da_err;
  logic [7:0]  fa_addr;
  logic [15:0] da_addr;
  logic [31:0] fa_instr, da_wdata, da_rdata;

  logic        fz_req, fz_ack, dz_req, dz_we, dz_ack, busy_z, dz_err;
  logic [7:0]  fz_addr;
  logic [15:0] dz_addr;
  logic [31:0] fz_instr, dz_wdata, dz_rdata;

  int checks = 0;
  int failures = 0;

  mem_responder #(.DEPTH(256), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(fa_req), .f_addr(fa_addr), .f_ack(fa_ack), .f_instr(fa_instr),
    .d_req(da_req), .d_we(da_we), .d_addr(da_addr), .d_wdata(da_wdata),
    .d_ack(da_ack), .d_rdata(da_rdata),
`ifdef MEM_RESP_ERR_EN
    .d_err(da_err),
`endif
    .busy(busy_a)
  );

  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .f_req(fz_req), .f_addr(fz_addr), .f_ack(fz_ack), .f_instr(fz_instr),
    .d_req(dz_req), .d_we(dz_we), .d_addr(dz_addr), .d_wdata(dz_wdata),
    .d_ack(dz_ack), .d_rdata(dz_rdata),
`ifdef MEM_RESP_ERR_EN
    .d_err(dz_err),
`endif
    .busy(busy_z)
  );

`ifndef MEM_RESP_ERR_EN
  assign da_err = 1'b0;
  assign dz_err = 1'b0;
`endif

  // Drives one transaction on instance sel (0: WAIT=1, 1: WAIT=0) and reports
  // ack latency in cycles after the accepting edge, returned word, d_err, and
  // whether the wrong ack fired or the ack lasted more than one cycle.
  task automatic txn(input bit sel, input bit is_data, input logic we,
                     input logic [15:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output int lat,
                     output logic err, output logic extra);
    logic own, oth;
    lat = -1; rdata = '0; err = 1'b0; extra = 1'b0;
    @(negedge clk);
    if (sel == 1'b0) begin
      if (is_data) begin da_req = 1; da_we = we; da_addr = addr; da_wdata = wdata; end
      else begin fa_req = 1; fa_addr = addr[7:0]; end
    end else begin
      if (is_data) begin dz_req = 1; dz_we = we; dz_addr = addr; dz_wdata = wdata; end
      else begin fz_req = 1; fz_addr = addr[7:0]; end
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sel == 1'b0) begin
        own = is_data ? da_ack : fa_ack;
        oth = is_data ? fa_ack : da_ack;
      end else begin
        own = is_data ? dz_ack : fz_ack;
        oth = is_data ? fz_ack : dz_ack;
      end
      if (oth) extra = 1'b1;
      if (own) begin
        lat = k;
        if (sel == 1'b0) begin rdata = is_data ? da_rdata : fa_instr; err = da_err; end
        else begin rdata = is_data ? dz_rdata : fz_instr; err = dz_err; end
        break;
      end
    end
    da_req = 0; fa_req = 0; dz_req = 0; fz_req = 0;
    @(negedge clk);
    if (sel == 1'b0) own = is_data ? da_ack : fa_ack;
    else own = is_data ? dz_ack : fz_ack;
    if (own) extra = 1'b1;
    $display("txn inst=%0d %s we=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b extra=%0b",
             sel, is_data ? "data " : "fetch", we, addr, wdata, lat, rdata, err, extra);
  endtask

  task automatic test_reset();
    rst_n = 0;
    fa_req = 0; fa_addr = '0; da_req = 0; da_we = 0; da_addr = '0; da_wdata = '0;
    fz_req = 0; fz_addr = '0; dz_req = 0; dz_we = 0; dz_addr = '0; dz_wdata = '0;
    #1;
    checks++; if (fa_ack !== 1'b0) begin failures++; $display("FAIL reset_f_ack got=%b want=0", fa_ack); end
    checks++; if (da_ack !== 1'b0) begin failures++; $display("FAIL reset_d_ack got=%b want=0", da_ack); end
    checks++; if (fa_instr !== 32'h0) begin failures++; $display("FAIL reset_f_instr got=%h want=0", fa_instr); end
    checks++; if (da_rdata !== 32'h0) begin failures++; $display("FAIL reset_d_rdata got=%h want=0", da_rdata); end
    checks++; if (busy_a !== 1'b0 || busy_z !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b want=00", busy_a, busy_z); end
    checks++; if (da_err !== 1'b0) begin failures++; $display("FAIL reset_d_err got=%b want=0", da_err); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Both requests raised together and held: data wins the first tie after reset.
  task automatic test_arbitration();
    int order [3];
    int n = 0;
    logic both = 1'b0;
    order[0] = -1; order[1] = -1; order[2] = -1;
    @(negedge clk);
    fa_req = 1; fa_addr = 8'h02; da_req = 1; da_we = 0; da_addr = 16'h0003;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (fa_ack && da_ack) both = 1'b1;
      if (da_ack) begin order[n] = 1; n++; end
      else if (fa_ack) begin order[n] = 0; n++; end
    end
    fa_req = 0; da_req = 0;
    $display("txn arbitration acks=%0d order=%0d,%0d,%0d (1=data)", n, order[0], order[1], order[2]);
    checks++; if (n != 3) begin failures++; $display("FAIL arb_count got=%0d want=3", n); end
    checks++; if (order[0] != 1) begin failures++; $display("FAIL arb_first got=%0d want=1(data)", order[0]); end
    checks++; if (order[1] != 0) begin failures++; $display("FAIL arb_second got=%0d want=0(fetch)", order[1]); end
    checks++; if (order[2] != 1) begin failures++; $display("FAIL arb_third got=%0d want=1(data)", order[2]); end
    checks++; if (both !== 1'b0) begin failures++; $display("FAIL arb_onehot got=%b want=0", both); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat; logic err, ex;
    txn(0, 1, 1, 16'h0010, 32'hDEADBEEF, rd, lat, err, ex);
    checks++; if (lat != 2) begin failures++; $display("FAIL wr_lat got=%0d want=2", lat); end
    checks++; if (ex !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wr_flags got=%b%b want=00", ex, err); end
    txn(0, 1, 0, 16'h0010, 32'h0, rd, lat, err, ex);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
    checks++; if (lat != 2) begin failures++; $display("FAIL rd_lat got=%0d want=2", lat); end
    checks++; if (ex !== 1'b0) begin failures++; $display("FAIL rd_onecycle got=%b want=0", ex); end
    checks++; if (da_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got=%h want=deadbeef", da_rdata); end
  endtask

  task automatic test_fetch();
    logic [31:0] rd; int lat; logic err, ex;
    txn(0, 1, 1, 16'h0005, 32'hE1A00000, rd, lat, err, ex);
    txn(0, 0, 0, 16'h0005, 32'h0, rd, lat, err, ex);
    checks++; if (rd !== 32'hE1A00000) begin failures++; $display("FAIL fetch_instr got=%h want=e1a00000", rd); end
    checks++; if (lat != 2) begin failures++; $display("FAIL fetch_lat got=%0d want=2", lat); end
    checks++; if (ex !== 1'b0) begin failures++; $display("FAIL fetch_onecycle got=%b want=0", ex); end
    checks++; if (fa_instr !== 32'hE1A00000) begin failures++; $display("FAIL fetch_hold got=%h want=e1a00000", fa_instr); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; logic err, ex;
    txn(0, 1, 1, 16'h0000, 32'h11111111, rd, lat, err, ex);
    txn(0, 1, 1, 16'h0100, 32'h12345678, rd, lat, err, ex);
    checks++; if (lat != 2) begin failures++; $display("FAIL oor_wr_lat got=%0d want=2", lat); end
`ifdef MEM_RESP_ERR_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b want=1", err); end
`endif
    txn(0, 1, 0, 16'h0100, 32'h0, rd, lat, err, ex);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_rd got=%h want=0", rd); end
    checks++; if (lat != 2) begin failures++; $display("FAIL oor_rd_lat got=%0d want=2", lat); end
    txn(0, 1, 0, 16'h0000, 32'h0, rd, lat, err, ex);
    checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL oor_alias got=%h want=11111111", rd); end
`ifdef MEM_RESP_ERR_EN
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL inrange_err got=%b want=0", err); end
`endif
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; int lat; logic err, ex;
    logic acked = 1'b0;
    txn(0, 1, 1, 16'h0020, 32'h5A5A5A5A, rd, lat, err, ex);
    txn(0, 1, 0, 16'h0020, 32'h0, rd, lat, err, ex);
    @(negedge clk);
    da_req = 1; da_we = 1; da_addr = 16'h0020; da_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rstw_busy_before got=%b want=1", busy_a); end
    rst_n = 0;
    #1;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%b want=0", busy_a); end
    checks++; if (da_ack !== 1'b0 || fa_ack !== 1'b0) begin failures++; $display("FAIL rstw_ack got=%b%b want=00", da_ack, fa_ack); end
    checks++; if (da_rdata !== 32'h0) begin failures++; $display("FAIL rstw_d_rdata got=%h want=0", da_rdata); end
    checks++; if (fa_instr !== 32'h0) begin failures++; $display("FAIL rstw_f_instr got=%h want=0", fa_instr); end
    da_req = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (da_ack || fa_ack) acked = 1'b1;
    end
    $display("txn reset during WAIT of write 0020=cafef00d acked=%0b", acked);
    checks++; if (acked !== 1'b0) begin failures++; $display("FAIL rstw_no_ack got=%b want=0", acked); end
    txn(0, 1, 0, 16'h0020, 32'h0, rd, lat, err, ex);
    checks++; if (rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL rstw_mem got=%h want=5a5a5a5a", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, r1, r2; int lat, lat1, lat2; logic err, ex, gap_busy, gap_ack;
    txn(1, 1, 1, 16'h0030, 32'hA5A5A5A5, rd, lat, err, ex);
    checks++; if (lat != 1) begin failures++; $display("FAIL b2b_wr_lat got=%0d want=1", lat); end
    txn(1, 1, 1, 16'h0031, 32'h0F0F0F0F, rd, lat, err, ex);
    lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    dz_req = 1; dz_we = 0; dz_addr = 16'h0030;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dz_ack) begin lat1 = k; r1 = dz_rdata; break; end
    end
    dz_addr = 16'h0031;
    @(negedge clk);
    gap_busy = busy_z; gap_ack = dz_ack;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dz_ack) begin lat2 = k; r2 = dz_rdata; break; end
    end
    dz_req = 0;
    $display("txn back-to-back reads lat1=%0d r1=%h gap_busy=%0b lat2=%0d r2=%h", lat1, r1, gap_busy, lat2, r2);
    checks++; if (lat1 != 1) begin failures++; $display("FAIL b2b_lat1 got=%0d want=1", lat1); end
    checks++; if (r1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_r1 got=%h want=a5a5a5a5", r1); end
    checks++; if (gap_busy !== 1'b0 || gap_ack !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b%b want=00", gap_busy, gap_ack); end
    checks++; if (lat2 != 1) begin failures++; $display("FAIL b2b_lat2 got=%0d want=1", lat2); end
    checks++; if (r2 !== 32'h0F0F0F0F) begin failures++; $display("FAIL b2b_r2 got=%h want=0f0f0f0f", r2); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_fetch();
    test_out_of_range();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
